spi_flash_responder: RTL
========================

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 Parameters SHALL be:
- JEDEC_ID, 24'h20BA19, bytes returned by READ ID (0x9F), MSB byte first.
- ADDR_W, 24, width of the flash byte address.

REQ-002 Ports SHALL be:
- ifclk  in  1  system clock; one clock; all logic on its rising edge.
- resetb  in  1  reset, asynchronous and active-low.
- sclk  in  1  SPI clock from the controller; asynchronous to ifclk.
- csb  in  1  SPI chip select, active-low; asynchronous.
- mosi  in  1  SPI data from the controller; asynchronous.
- miso  out  1  SPI data to the controller.
- miso_oe  out  1  tristate enable for miso; 1 = drive.
- wel  out  1  write-enable latch (status bit 1).
- mem_addr  out  ADDR_W  byte address for backing-store access.
- mem_rd  out  1  one-cycle read strobe.
- mem_rdata  in  8  read data, valid the cycle after mem_rd.
- mem_wr  out  1  one-cycle write strobe.
- mem_wdata  out  8  write data, qualified by mem_wr.

Function
REQ-003 sclk, csb and mosi SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized sclk.
REQ-004 The supported input timing SHALL be: sclk high and low phases >= 4 ifclk cycles each.
REQ-005 Protocol SHALL be SPI mode 0, MSB first:
- mosi sampled on each detected sclk rise.
- miso updated on each detected sclk fall.
REQ-006 A detected csb fall SHALL enter CMD with the bit counter at 0.
REQ-007 States SHALL be IDLE, CMD, ADDR, DUMMY, DOUT, DIN, IGNORE.
REQ-008 After 8 bits in CMD, the next state SHALL be set by the opcode:
- 0x06: wel <= 1, then IGNORE.
- 0x04: wel <= 0, then IGNORE.
- 0x05: DOUT sending {6'b0, wel, 1'b0}, repeated for every following byte.
- 0x9F: DOUT sending JEDEC_ID bytes, then 0x00 for every following byte.
- 0x03 or 0x02: ADDR.
- any other opcode: IGNORE.
REQ-009 ADDR SHALL shift in 3 address bytes, MSB first.
- For 0x03, it SHALL then assert mem_rd for one cycle with mem_addr = address and enter DOUT.
- For 0x02, it SHALL then enter DIN.
REQ-010 DOUT for 0x03 SHALL load each data byte from mem_rdata.
- After each 8th sclk rise, the address SHALL increment modulo 2^ADDR_W and mem_rd SHALL pulse for the next byte.
- The next byte SHALL be loaded before the next detected sclk fall.
REQ-011 DIN SHALL, on each completed byte, behave as follows:
- If wel = 1: pulse mem_wr for one cycle with the current mem_addr and mem_wdata.
- The address SHALL increment within the 256-byte page: bits [7:0] wrap and the upper bits are held.
- If wel = 0: no mem_wr is issued.
REQ-012 A detected csb rise SHALL return the block to IDLE from any state.
- A partial byte SHALL be discarded with no mem_wr.
- If opcode 0x02 received at least 4 complete bytes, wel SHALL clear on the csb rise.
REQ-013 miso_oe SHALL be 1 only in DOUT (and DUMMY when configured); miso SHALL be 0 whenever miso_oe is 0.
REQ-014 mem_rd and mem_wr SHALL never both be asserted in the same cycle; each SHALL be exactly one cycle wide.
REQ-015 A csb fall while not in IDLE SHALL cannot occur without an intervening rise (per REQ-012); if the synchronizer reports both within 1 cycle, the block SHALL treat it as rise then fall.

Reset
REQ-016 While resetb is low, the block SHALL hold:
- state IDLE, wel 0, miso 0, miso_oe 0, mem_rd 0, mem_wr 0.
- mem_addr 0, mem_wdata 0, all counters and synchronizers 0.
- csb synchronizer at 1.
REQ-017 A reset asserted mid-transaction SHALL abort the transaction with no further memory strobes; after reset release, the block SHALL wait for the next csb fall.

Configuration
REQ-018 With SPI_FLASH_RESP_FAST_READ_EN defined, opcode 0x0B SHALL take:
- 3 address bytes.
- then DUMMY for 8 sclk cycles, with miso driven 0 and mem_rd issued at DUMMY entry.
- then DOUT as for 0x03.
REQ-019 Without SPI_FLASH_RESP_FAST_READ_EN, 0x0B SHALL be treated as an unknown opcode (IGNORE) and the DUMMY state SHALL not exist.

Verification
REQ-020 Send 0x9F plus 4 bytes, with sclk half-period 4 ifclk -> miso bytes 0x20, 0xBA, 0x19, 0x00.
REQ-021 Send 0x06, csb high, then 0x02, 0x00, 0x01, 0xFE, then 0xAA, 0xBB, 0xCC -> mem_wr at addresses 0x0001FE, 0x0001FF, 0x000100 with data AA, BB, CC; wel = 0 after the csb rise.
REQ-022 Send 0x02 with wel = 0 and 2 data bytes -> no mem_wr pulse.
REQ-023 Send 0x03, 0xFF, 0xFF, 0xFF and read 2 bytes -> mem_rd at 0xFFFFFF then 0x000000; miso carries the returned mem_rdata.
REQ-024 Raise csb after 5 bits of a DIN data byte -> no mem_wr; state IDLE; miso_oe = 0 within 3 cycles.
REQ-025 Assert resetb low during DOUT of 0x05 -> all outputs return to reset values; the next 0x05 transaction returns 0x00.

Source files
------------

// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   SPI mode-0 serial-flash target that sits on a parallel byte-wide backing
//   store. Every SPI pin is synchronized into ifclk and sclk edges are found
//   on the synchronized copy. Supported opcodes: WREN (06), WRDI (04),
//   RDSR (05), RDID (9F), READ (03), PAGE PROGRAM (02).
//   Optional build macro SPI_FLASH_RESP_FAST_READ_EN adds FAST READ (0B):
//   3 address bytes, 8 dummy clocks, then read data.
//
// Ports
//   ifclk, resetb      system clock, asynchronous active-low reset
//   sclk, csb, mosi    SPI inputs (asynchronous to ifclk)
//   miso, miso_oe      SPI output and its tristate enable (1 = drive)
//   wel                write-enable latch (status bit 1)
//   mem_addr           backing-store byte address
//   mem_rd, mem_rdata  one-cycle read strobe; data valid the following cycle
//   mem_wr, mem_wdata  one-cycle write strobe with its data
module spi_flash_responder #(
  parameter logic [23:0] JEDEC_ID = 24'h20BA19,
  parameter int          ADDR_W   = 24
) (
  input  logic              ifclk,
  input  logic              resetb,
  input  logic              sclk,
  input  logic              csb,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              wel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DOUT   = 3'd3,
    S_DIN    = 3'd4,
`ifdef SPI_FLASH_RESP_FAST_READ_EN
    S_DUMMY  = 3'd6,
`endif
    S_IGNORE = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        sclk_sync_q, sclk_sync_d;
  logic [1:0]        csb_sync_q, csb_sync_d;
  logic [1:0]        mosi_sync_q, mosi_sync_d;
  logic              sclk_prev_q, sclk_prev_d;
  logic              csb_prev_q, csb_prev_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;   // complete bytes this transaction, saturating
  logic [1:0]        id_idx_q, id_idx_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ld_q, ld_d;               // mem_rdata is valid this cycle
  logic              inc_q, inc_d;             // post-write in-page address increment
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic              wel_q, wel_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;

  logic       sclk_rise, sclk_fall, csb_rise, csb_fall, byte_done;
  logic [7:0] rx_byte;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;
  assign csb_rise  = csb_sync_q[1] & ~csb_prev_q;
  assign csb_fall  = ~csb_sync_q[1] & csb_prev_q;
  assign rx_byte   = {rx_q[6:0], mosi_sync_q[1]};
  assign byte_done = sclk_rise && (state_q != S_IDLE) && (bit_cnt_q == 3'd7);

  always_comb begin
    state_d     = state_q;
    sclk_sync_d = {sclk_sync_q[0], sclk};
    csb_sync_d  = {csb_sync_q[0], csb};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    sclk_prev_d = sclk_sync_q[1];
    csb_prev_d  = csb_sync_q[1];
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    id_idx_d    = id_idx_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    op_d        = op_q;
    addr_d      = addr_q;
    ld_d        = mem_rd_q;
    inc_d       = 1'b0;
    miso_d      = miso_q;
    miso_oe_d   = 1'b0;
    wel_d       = wel_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;

    if (ld_q) tx_d = mem_rdata;
    if (inc_q) addr_d = {addr_q[ADDR_W-1:8], addr_q[7:0] + 8'd1};

    if (sclk_rise && state_q != S_IDLE) begin
      rx_d      = rx_byte;
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    if (byte_done && byte_cnt_q != 3'd7) byte_cnt_d = byte_cnt_q + 3'd1;

    // Shift the outgoing byte on sclk fall so the controller samples it on the next rise.
    if (sclk_fall && state_q == S_DOUT) begin
      miso_d = tx_q[7];
      tx_d   = {tx_q[6:0], 1'b0};
    end

    if (byte_done) begin
      case (state_q)
        S_CMD: begin
          op_d = rx_byte;
          case (rx_byte)
            8'h06: begin wel_d = 1'b1; state_d = S_IGNORE; end
            8'h04: begin wel_d = 1'b0; state_d = S_IGNORE; end
            8'h05: begin tx_d = {6'b0, wel_q, 1'b0}; state_d = S_DOUT; end
            8'h9F: begin tx_d = JEDEC_ID[23:16]; id_idx_d = 2'd1; state_d = S_DOUT; end
            8'h03, 8'h02: state_d = S_ADDR;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
            8'h0B: state_d = S_ADDR;
`endif
            default: state_d = S_IGNORE;
          endcase
        end
        S_ADDR: begin
          addr_d = {addr_q[ADDR_W-9:0], rx_byte};
          // Opcode is byte 1, so the third address byte completes with three bytes already counted.
          if (byte_cnt_q == 3'd3) begin
            case (op_q)
              8'h03: begin mem_rd_d = 1'b1; state_d = S_DOUT; end
`ifdef SPI_FLASH_RESP_FAST_READ_EN
              8'h0B: begin mem_rd_d = 1'b1; state_d = S_DUMMY; end
`endif
              default: state_d = S_DIN;
            endcase
          end
        end
        S_DOUT: begin
          if (op_q == 8'h05) begin
            tx_d = {6'b0, wel_q, 1'b0};
          end else if (op_q == 8'h9F) begin
            case (id_idx_q)
              2'd1:    tx_d = JEDEC_ID[15:8];
              2'd2:    tx_d = JEDEC_ID[7:0];
              default: tx_d = 8'h00;
            endcase
            if (id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
          end else begin
            addr_d   = addr_q + 1'b1;
            mem_rd_d = 1'b1;
          end
        end
        S_DIN: begin
          // Strobe with the current address; the in-page increment lands the cycle after.
          if (wel_q) begin
            mem_wr_d    = 1'b1;
            mem_wdata_d = rx_byte;
          end
          inc_d = 1'b1;
        end
`ifdef SPI_FLASH_RESP_FAST_READ_EN
        S_DUMMY: state_d = S_DOUT;
`endif
        default: ;
      endcase
    end

    // Rise is handled before fall so a simultaneous report ends one transaction and starts the next.
    if (csb_rise) begin
      if (op_q == 8'h02 && byte_cnt_q >= 3'd4) wel_d = 1'b0;
      state_d = S_IDLE;
    end
    if (csb_fall) begin
      state_d    = S_CMD;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 3'd0;
      id_idx_d   = 2'd0;
      op_d       = 8'h00;
    end

`ifdef SPI_FLASH_RESP_FAST_READ_EN
    miso_oe_d = (state_d == S_DOUT) || (state_d == S_DUMMY);
    if (state_d == S_DUMMY) miso_d = 1'b0;
`else
    miso_oe_d = (state_d == S_DOUT);
`endif
    if (!miso_oe_d) miso_d = 1'b0;
  end

  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= S_IDLE;
      sclk_sync_q <= 2'b00;
      csb_sync_q  <= 2'b11;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      csb_prev_q  <= 1'b1;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 3'd0;
      id_idx_q    <= 2'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      op_q        <= 8'h00;
      addr_q      <= '0;
      ld_q        <= 1'b0;
      inc_q       <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      wel_q       <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      csb_sync_q  <= csb_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      csb_prev_q  <= csb_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      id_idx_q    <= id_idx_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      ld_q        <= ld_d;
      inc_q       <= inc_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      wel_q       <= wel_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = miso_oe_q;
  assign wel       = wel_q;
  assign mem_addr  = addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
